// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch-predictor
// exchange, execute redirect and the fetch-queue head toward decode.
interface if_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;

  logic [XLEN-1:0] if_pc;
  logic [31:0]     inst;
  logic            inst_valid;
  logic [XLEN-1:0] bp_pc;
  logic            bp_taken;

  logic            ex_redirect;
  logic [XLEN-1:0] ex_redirect_pc;

  logic            fq_valid;
  logic [31:0]     fq_inst;
  logic [XLEN-1:0] fq_pc;
  logic [XLEN-1:0] fq_npc;
  logic            fq_pred_taken;
  logic            fq_ready;

  // The fetch controller drives the master side.
  modport master (
    output mem_req_valid, mem_req_addr, if_pc, inst, inst_valid,
           fq_valid, fq_inst, fq_pc, fq_npc, fq_pred_taken,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, bp_pc, bp_taken,
           ex_redirect, ex_redirect_pc, fq_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, if_pc, inst, inst_valid,
           fq_valid, fq_inst, fq_pc, fq_npc, fq_pred_taken,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, bp_pc, bp_taken,
           ex_redirect, ex_redirect_pc, fq_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, keeps one instruction fetch in
// flight, consults the predictor on each response and buffers results for decode.
module if_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  if_fetch_ctrl_if.master bus
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FQ_DEPTH must be a power of two and at least 2");
  end

  // DROP means a fetch is outstanding whose data must be thrown away.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            taken;
  } fq_entry_t;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  fq_entry_t        fq_mem_q [FQ_DEPTH];

  logic             fq_pop;
  logic             fq_push;
  logic             req_valid;
  logic [CNT_W-1:0] count_after_pop;
  fq_entry_t        head;
  fq_entry_t        new_entry;

  assign fq_pop          = (count_q != '0) && bus.fq_ready;
  assign count_after_pop = count_q - CNT_W'(fq_pop);
  assign new_entry       = '{inst: bus.mem_rsp_data, pc: pc_q, npc: bus.bp_pc, taken: bus.bp_taken};

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    req_valid = 1'b0;
    fq_push   = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        // Request gating doubles as the guarantee that a response always finds a free slot.
        req_valid = reset && (count_after_pop < CNT_W'(FQ_DEPTH));
        if (req_valid && bus.mem_req_ready) begin
          state_d = bus.ex_redirect ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d = ST_REQ;
          fq_push = !bus.ex_redirect;
        end else if (bus.ex_redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.mem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (bus.ex_redirect) begin
      pc_d     = bus.ex_redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (fq_push) begin
        pc_d     = bus.bp_pc;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (fq_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(fq_push) - CNT_W'(fq_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; validity lives in count_q,
  // and the head outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (fq_push) begin
      fq_mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head = fq_mem_q[rd_ptr_q];

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = pc_q;
  assign bus.if_pc         = pc_q;
  assign bus.inst          = bus.mem_rsp_data;
  assign bus.inst_valid    = fq_push;

  assign bus.fq_valid      = (count_q != '0);
  assign bus.fq_inst       = bus.fq_valid ? head.inst  : '0;
  assign bus.fq_pc         = bus.fq_valid ? head.pc    : '0;
  assign bus.fq_npc        = bus.fq_valid ? head.npc   : '0;
  assign bus.fq_pred_taken = bus.fq_valid && head.taken;

  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
    !(fq_push && !fq_pop && count_q == CNT_W'(FQ_DEPTH)));

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage controller that owns the architectural fetch PC and issues one instruction-memory request at a time.
- Presents each returned instruction and its PC to the branch predictor, then takes the predictor's next-PC and taken flag in the same cycle.
- Pushes {inst, pc, predicted npc, taken} into a small fetch queue that decode drains.
- An execute-stage redirect flushes the queue and the in-flight fetch.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 0, fetch PC loaded on reset.
- FQ_DEPTH, 4, fetch queue entries (power of two, >=2).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  XLEN  fetch address (= pc register)
- mem_req_ready  in  1  memory accepts request this cycle
- mem_rsp_valid  in  1  instruction data returned
- mem_rsp_data  in  32  returned instruction
- if_pc  out  XLEN  PC of outstanding fetch, to predictor
- inst  out  32  instruction to predictor (= mem_rsp_data)
- inst_valid  out  1  predictor valid; high only for a non-stale response
- bp_pc  in  XLEN  predicted next PC from predictor
- bp_taken  in  1  predicted-taken flag from predictor
- ex_redirect  in  1  mispredict/redirect from execute
- ex_redirect_pc  in  XLEN  corrected PC
- fq_valid  out  1  queue head valid
- fq_inst  out  32  head instruction
- fq_pc  out  XLEN  head PC
- fq_npc  out  XLEN  head predicted next PC
- fq_pred_taken  out  1  head predicted-taken
- fq_ready  in  1  decode pops head when fq_valid && fq_ready

Behaviour:
- Reset (async, reset==0):
  - pc=RESET_PC; state=REQ; queue empty (count=0, pointers 0).
  - All outputs 0 except mem_req_addr/if_pc=RESET_PC.
- State REQ:
  - mem_req_valid = (count_after_pop < FQ_DEPTH), where count_after_pop = count - (fq_valid&&fq_ready).
  - On mem_req_valid && mem_req_ready, go to WAIT.
- State WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid: inst_valid=1 combinationally the same cycle; predictor answers combinationally.
  - Clock edge: enqueue {mem_rsp_data, pc, bp_pc, bp_taken}; pc<=bp_pc; go to REQ.
  - Response latency is arbitrary (>=1 cycle after acceptance). The free slot is guaranteed by the REQ gating; at most one fetch is outstanding.
- State DROP (stale fetch in flight):
  - mem_req_valid=0; inst_valid=0.
  - On mem_rsp_valid, discard data and go to REQ.
- Redirect (ex_redirect=1) has highest priority, in any state:
  - Set pc<=ex_redirect_pc and flush the queue (count=0, pointers reset). No pop is counted that cycle.
  - REQ without handshake: stay in REQ.
  - REQ with handshake the same cycle: go to DROP.
  - WAIT with no response: go to DROP.
  - WAIT with a response the same cycle: discard the response, inst_valid=0, go to REQ.
  - DROP: stay in DROP, or go to REQ if the stale response arrives that cycle.
- Queue:
  - Circular buffer with registered head outputs; fq_valid = (count != 0). An entry is visible the cycle after enqueue.
  - Pointers wrap modulo FQ_DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - Enqueue when full is impossible by construction; assert in simulation.
  - fq_* data fields are don't-care when fq_valid=0.
- Widths:
  - pc and npc are full XLEN; no alignment check.
  - bp_pc is used verbatim, including pc+4 wrap at 2^XLEN.

Test Plan:
1. Reset, then mem_req_ready=1 and 1-cycle responses with inst=0x00000013, bp_pc=pc+4 → mem_req_addr sequence 0x0,0x4,0x8; fq entries pc=0x0/npc=0x4; fq_pred_taken=0.
2. Response at pc=0x10 with bp_taken=1, bp_pc=0x40 → next mem_req_addr=0x40; enqueued entry npc=0x40, pred_taken=1.
3. fq_ready=0 with FQ_DEPTH=4 → exactly 4 entries fill, then mem_req_valid=0. Assert fq_ready for 1 cycle → mem_req_valid reasserts that same cycle.
4. Redirect to 0x200 while in WAIT, response arriving 3 cycles later → response discarded (inst_valid=0), queue empty, next request addr=0x200.
5. Redirect to 0x300 in the same cycle as mem_rsp_valid → no enqueue, REQ next cycle with addr=0x300. Redirect in the same cycle as a request handshake → DROP; first post-response request is addr=0x300.
6. Assert reset mid-WAIT → outputs clear immediately (async). After release, request addr=RESET_PC; a late stale response before the new request is ignored.
